// File: rtl/elastic_pipe_register_pkg.sv
// Shared definitions for the elastic pipeline register: depth limit and occupancy sizing.
package elastic_pipe_register_pkg;

  localparam int unsigned PIPE_MAX_DEPTH = 4;

  // Two slots (main + skid) per stage, so the count spans 0..2*depth inclusive.
  function automatic int unsigned pipe_occ_width(input int unsigned depth);
    return $clog2(2 * depth + 1);
  endfunction

  localparam int unsigned PIPE_OCC_W = pipe_occ_width(PIPE_MAX_DEPTH);

  typedef logic [PIPE_OCC_W-1:0] pipe_occ_t;

endpackage

// File: rtl/pipe_skid_stage.sv
// One skid-buffered pipeline stage: main slot drives the output, skid slot absorbs the entry
// that arrives while main is stalled, so In_Ready can come straight from a flop.
module pipe_skid_stage #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             Flush,
  input  logic             In_Valid,
  output logic             In_Ready,
  input  logic [WIDTH-1:0] In_Payload,
  output logic             Out_Valid,
  input  logic             Out_Ready,
  output logic [WIDTH-1:0] Out_Payload
);

  logic             main_valid_q;
  logic             skid_valid_q;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] skid_q;

  logic in_fire;
  logic main_free;

  assign In_Ready    = ~skid_valid_q;
  assign in_fire     = In_Valid & In_Ready;
  // Main can take a new entry when empty or when its current entry leaves on this edge.
  assign main_free   = ~main_valid_q | Out_Ready;
  assign Out_Valid   = main_valid_q;
  assign Out_Payload = main_q;

  always_ff @(posedge CLK) begin
    if (!RST_N || Flush) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
    end else if (main_free) begin
      // skid_valid_q and in_fire are mutually exclusive (In_Ready = !skid_valid_q).
      main_valid_q <= skid_valid_q | in_fire;
      skid_valid_q <= 1'b0;
    end else if (in_fire) begin
      skid_valid_q <= 1'b1;
    end
  end

  // Payload flops carry no reset; validity alone decides whether they mean anything.
  always_ff @(posedge CLK) begin
    if (main_free) begin
      if (skid_valid_q) begin
        main_q <= skid_q;
      end else if (in_fire) begin
        main_q <= In_Payload;
      end
    end else if (in_fire) begin
      skid_q <= In_Payload;
    end
  end

endmodule

// File: rtl/elastic_pipe_register.sv
// Back-pressurable inter-stage pipeline register: DEPTH chained skid stages, enable masking on
// bubbles, a registered occupancy count and a zero-latency bypass lane.
module elastic_pipe_register
  import elastic_pipe_register_pkg::*;
#(
  parameter int unsigned       CTRL_W       = 5,
  parameter logic [CTRL_W-1:0] CTRL_EN_MASK = CTRL_W'(1),
  parameter int unsigned       DATA_W       = 69,
  parameter int unsigned       BYPASS_W     = 32,
  parameter int unsigned       DEPTH        = 1,
  localparam int unsigned      OCC_W        = $clog2(2 * DEPTH + 1)
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                Flush,
  input  logic                In_Valid,
  output logic                In_Ready,
  input  logic [CTRL_W-1:0]   In_Ctrl,
  input  logic [DATA_W-1:0]   In_Data,
  output logic                Out_Valid,
  input  logic                Out_Ready,
  output logic [CTRL_W-1:0]   Out_Ctrl,
  output logic [DATA_W-1:0]   Out_Data,
  input  logic [BYPASS_W-1:0] Bypass_In,
  output logic [BYPASS_W-1:0] Bypass_Out,
  output logic [OCC_W-1:0]    Occupancy
);

  localparam int unsigned PAY_W = CTRL_W + DATA_W;

  if (DEPTH < 1 || DEPTH > PIPE_MAX_DEPTH || BYPASS_W < 1) begin : g_param_check
    $fatal(1, "elastic_pipe_register: DEPTH must be 1..%0d and BYPASS_W >= 1", PIPE_MAX_DEPTH);
  end

  // Chain links: index 0 is the upstream port, index DEPTH the downstream port.
  logic [DEPTH:0]   valid_c;
  logic [DEPTH:0]   ready_c;
  logic [PAY_W-1:0] payload_c [DEPTH+1];

  assign valid_c[0]     = In_Valid;
  assign payload_c[0]   = {In_Ctrl, In_Data};
  assign In_Ready       = ready_c[0];
  assign ready_c[DEPTH] = Out_Ready;

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    pipe_skid_stage #(
      .WIDTH (PAY_W)
    ) u_stage (
      .CLK         (CLK),
      .RST_N       (RST_N),
      .Flush       (Flush),
      .In_Valid    (valid_c[i]),
      .In_Ready    (ready_c[i]),
      .In_Payload  (payload_c[i]),
      .Out_Valid   (valid_c[i+1]),
      .Out_Ready   (ready_c[i+1]),
      .Out_Payload (payload_c[i+1])
    );
  end

  logic [CTRL_W-1:0] main_ctrl;

  assign Out_Valid = valid_c[DEPTH];
  assign main_ctrl = payload_c[DEPTH][PAY_W-1:DATA_W];
  assign Out_Data  = payload_c[DEPTH][DATA_W-1:0];
  // State-changing enables are forced low on bubbles so stale payload never commits.
  assign Out_Ctrl  = main_ctrl & ~(Out_Valid ? {CTRL_W{1'b0}} : CTRL_EN_MASK);

  assign Bypass_Out = Bypass_In;

  logic             in_fire;
  logic             out_fire;
  logic [OCC_W-1:0] occ_q;
  logic [OCC_W-1:0] occ_d;

  assign in_fire   = In_Valid & In_Ready;
  assign out_fire  = Out_Valid & Out_Ready;
  assign Occupancy = occ_q;

  always_comb begin
    occ_d = occ_q;
    if (Flush) begin
      occ_d = '0;
    end else begin
      unique case ({in_fire, out_fire})
        2'b10:   occ_d = occ_q + OCC_W'(1);
        2'b01:   occ_d = occ_q - OCC_W'(1);
        default: occ_d = occ_q;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_d;
    end
  end

endmodule
